// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Shared definitions for the I2S transmit and receive paths.
//   SAMPLE_W_DEFAULT : default audio sample width (bits)
//   SLOT_W_DEFAULT   : BCLK periods per channel slot
//   FRAME_BITS       : BCLK periods per stereo frame (two slots)
//   i2s_state_e      : serialiser state (IDLE, RUN, DRAIN)
// ---------------------------------------------------------------------------
package i2s_pkg;

    localparam int SAMPLE_W_DEFAULT = 18;
    localparam int SLOT_W_DEFAULT   = 32;
    localparam int FRAME_BITS       = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } i2s_state_e;

endpackage

// File: rtl/i2s_bclk_gen.sv
// ---------------------------------------------------------------------------
// i2s_bclk_gen
// Divides clk down to the I2S bit clock. While run is low the divider and
// BCLK are held at 0, so the first edge after run rises is always a rising
// BCLK edge CLK_DIV cycles later.
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   run       : 1 = generate BCLK, 0 = hold divider and BCLK at 0
//   bclk      : registered bit clock, period 2*CLK_DIV clk cycles
//   bclk_rise : 1 in the clk cycle whose rising edge drives bclk 0->1
//   bclk_fall : 1 in the clk cycle whose rising edge drives bclk 1->0
// ---------------------------------------------------------------------------
module i2s_bclk_gen
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic bclk,
    output logic bclk_rise,
    output logic bclk_fall
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div_q, div_d;
    logic       bclk_q, bclk_d;
    logic       toggle;

    always_comb begin
        toggle = run && (div_q == DIV_LAST);
        div_d  = div_q;
        bclk_d = bclk_q;
        if (!run) begin
            div_d  = 8'd0;
            bclk_d = 1'b0;
        end else if (toggle) begin
            div_d  = 8'd0;
            bclk_d = !bclk_q;
        end else begin
            div_d  = div_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q  <= 8'd0;
            bclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            bclk_q <= bclk_d;
        end
    end

    // Strobes mark the cycle before the BCLK edge so the caller's registers
    // change on the very same clk edge as BCLK.
    assign bclk      = bclk_q;
    assign bclk_rise = toggle && !bclk_q;
    assign bclk_fall = toggle && bclk_q;

endmodule

// File: rtl/i2s_transmitter.sv
// ---------------------------------------------------------------------------
// i2s_transmitter
// Serialises stereo sample pairs into a standard I2S stream (MSB one BCLK
// after each LRCLK edge, 32 BCLK slots per channel). A single holding
// register decouples the valid/ready input from the frame timing.
//   clk          : system clock
//   reset        : asynchronous active-low reset
//   enable       : 1 = transmit frames, 0 = stop at next frame boundary
//   sample_l/r   : two's complement stereo pair
//   sample_valid : pair offered
//   sample_ready : holding register empty
//   BCLK, LRCLK, SDATA : I2S outputs to the DAC
//   underrun     : one-cycle pulse when a frame starts with nothing held
// ---------------------------------------------------------------------------
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
    parameter int SLOT_W   = SLOT_W_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                BCLK,
    output logic                LRCLK,
    output logic                SDATA,
    output logic                underrun
);

    localparam logic [5:0] LAST_BIT = 6'(2 * SLOT_W - 1);
    localparam logic [4:0] SW5      = 5'(SAMPLE_W);

    i2s_state_e          state_q, state_d;
    logic [5:0]          bit_cnt_q, bit_cnt_d;
    logic                lrclk_q, lrclk_d;
    logic                sdata_q, sdata_d;
    logic                hold_full_q, hold_full_d;
    logic [SAMPLE_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [SAMPLE_W-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;

    logic       bclk_rise, bclk_fall;
    logic       frame_start, accept, wrap;
    logic [5:0] next_cnt;

    // Slot positions 1..SAMPLE_W carry data; position 0 is the I2S delay bit.
    function automatic logic is_data_bit(input logic [5:0] cnt);
        return (cnt[4:0] != 5'd0) && (cnt[4:0] <= SW5);
    endfunction

    i2s_bclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_bclk_gen (
        .clk       (clk),
        .reset     (reset),
        .run       (state_q != IDLE),
        .bclk      (BCLK),
        .bclk_rise (bclk_rise),
        .bclk_fall (bclk_fall)
    );

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        lrclk_d     = lrclk_q;
        sdata_d     = sdata_q;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        sh_l_d      = sh_l_q;
        sh_r_d      = sh_r_q;
        frame_start = 1'b0;
        accept      = sample_valid && !hold_full_q;
        wrap        = bclk_fall && (bit_cnt_q == LAST_BIT);
        next_cnt    = bit_cnt_q + 6'd1;

        case (state_q)
            IDLE: begin
                bit_cnt_d = 6'd0;
                lrclk_d   = 1'b1;
                sdata_d   = 1'b0;
                if (enable) begin
                    state_d     = RUN;
                    frame_start = 1'b1;
                    lrclk_d     = 1'b0;
                end
            end
            default: begin
                // SDATA and LRCLK only move on BCLK falling edges; the value
                // presented is the one for the slot position being entered.
                if (bclk_fall) begin
                    bit_cnt_d = next_cnt;
                    lrclk_d   = next_cnt[5];
                    if (is_data_bit(next_cnt))
                        sdata_d = next_cnt[5] ? sh_r_q[SAMPLE_W-1] : sh_l_q[SAMPLE_W-1];
                    else
                        sdata_d = 1'b0;
                end
                // The DAC has latched the current bit on the rising edge, so
                // advance that channel's shift register ready for the next fall.
                if (bclk_rise && is_data_bit(bit_cnt_q)) begin
                    if (bit_cnt_q[5])
                        sh_r_d = sh_r_q << 1;
                    else
                        sh_l_d = sh_l_q << 1;
                end
                if (state_q == RUN) begin
                    if (!enable)
                        state_d = DRAIN;
                    if (wrap)
                        frame_start = 1'b1;
                end else begin
                    if (enable) begin
                        state_d = RUN;
                        if (wrap)
                            frame_start = 1'b1;
                    end else if (wrap) begin
                        state_d   = IDLE;
                        bit_cnt_d = 6'd0;
                        lrclk_d   = 1'b1;
                        sdata_d   = 1'b0;
                    end
                end
            end
        endcase

        if (frame_start) begin
            sh_l_d      = hold_full_q ? hold_l_q : '0;
            sh_r_d      = hold_full_q ? hold_r_q : '0;
            hold_full_d = 1'b0;
        end
        // accept implies the register was empty, so it cannot collide with
        // the frame-start copy above; a pair arriving then waits one frame.
        if (accept) begin
            hold_l_d    = sample_l;
            hold_r_d    = sample_r;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 6'd0;
            lrclk_q     <= 1'b1;
            sdata_q     <= 1'b0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            sh_l_q      <= '0;
            sh_r_q      <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            lrclk_q     <= lrclk_d;
            sdata_q     <= sdata_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            sh_l_q      <= sh_l_d;
            sh_r_q      <= sh_r_d;
        end
    end

    assign LRCLK        = lrclk_q;
    assign SDATA        = sdata_q;
    assign sample_ready = !hold_full_q;
    assign underrun     = frame_start && !hold_full_q;

endmodule
